// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Purpose
//   Serial UART transmitter. Takes bytes from an AXI-Stream style slave port
//   and shifts them out LSB first as 8N1 / 8N2 frames on o_txd, with an
//   optional parity bit. Single clock domain; every register updates on the
//   rising edge of i_clk.
//
// Build option
//   UART_TX_PARITY_EN  when defined, a parity bit is sent after data bit 7.
//                      PARITY_ODD selects the sense (0 = even, 1 = odd).
//                      When undefined there is no parity state or logic.
//
// Parameters
//   CLKS_PER_BIT  i_clk cycles per serial bit (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//   PARITY_ODD    parity sense, used only with UART_TX_PARITY_EN
//
// Ports
//   i_clk            in   transfer clock
//   i_rst            in   synchronous reset, active high
//   i_s_axis_tvalid  in   producer has a byte
//   i_s_axis_tdata   in   byte to transmit [7:0]
//   o_s_axis_tready  out  block can accept a byte this cycle
//   o_txd            out  serial line, idle high (registered)
//   o_txd_busy       out  frame in progress
// ---------------------------------------------------------------------------
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | line high, counters held at 0, ready for a byte
// ST_START  | start bit (0) on the line
// ST_DATA   | data bits 0..7, LSB first, bit_cnt selects the bit
// ST_PARITY | parity bit (only with UART_TX_PARITY_EN)
// ST_STOP   | stop bit(s) (1); stop_cnt selects which one
//
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_s_axis_tvalid,
    input  logic [7:0] i_s_axis_tdata,
    output logic       o_s_axis_tready,
    output logic       o_txd,
    output logic       o_txd_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    // An illegal parameter set leaves the transmitter permanently not ready,
    // so a misconfigured instance is obvious on the first transfer attempt.
    localparam bit CFG_OK = (CLKS_PER_BIT >= 2) &&
                            ((STOP_BITS == 1) || (STOP_BITS == 2)) &&
                            ((PARITY_ODD == 0) || (PARITY_ODD == 1));

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [2:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic          stop_cnt;
    logic [7:0]    shift_reg;
    logic          txd_q;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
`endif

    logic bit_end;
    logic last_stop;
    logic accept;

    assign bit_end   = (clk_cnt == CLK_LAST);
    assign last_stop = (STOP_BITS == 1) || stop_cnt;

    // Ready is decoded from registered state only; the last stop cycle also
    // counts as ready so back-to-back frames have no idle gap.
    assign o_s_axis_tready = CFG_OK && !i_rst &&
                             ((state == ST_IDLE) ||
                              ((state == ST_STOP) && last_stop && bit_end));

    assign accept     = i_s_axis_tvalid && o_s_axis_tready;
    assign o_txd      = txd_q;
    assign o_txd_busy = (state != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= 3'd0;
            stop_cnt  <= 1'b0;
            shift_reg <= 8'd0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (accept) begin
            // Only reachable from IDLE or the final stop cycle.
            state     <= ST_START;
            clk_cnt   <= '0;
            bit_cnt   <= 3'd0;
            stop_cnt  <= 1'b0;
            shift_reg <= i_s_axis_tdata;
            txd_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= (^i_s_axis_tdata) ^ 1'(PARITY_ODD);
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    clk_cnt  <= '0;
                    bit_cnt  <= 3'd0;
                    stop_cnt <= 1'b0;
                    txd_q    <= 1'b1;
                end

                ST_START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        state     <= ST_DATA;
                        txd_q     <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        // Wraps 7 -> 0 on the way out of DATA.
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            txd_q <= parity_q;
`else
                            state    <= ST_STOP;
                            stop_cnt <= 1'b0;
                            txd_q    <= 1'b1;
`endif
                        end else begin
                            txd_q     <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        clk_cnt  <= '0;
                        state    <= ST_STOP;
                        stop_cnt <= 1'b0;
                        txd_q    <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (last_stop) begin
                            // No byte offered in the final stop cycle.
                            state    <= ST_IDLE;
                            stop_cnt <= 1'b0;
                            txd_q    <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    clk_cnt <= '0;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: table of bytes with hand-written frames,
// plus sequences for back-to-back, backpressure and mid-frame reset.
module tb_uart_tx_ctrl;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int SB = 2;
    localparam int NB = 12;
`else
    localparam int SB = 1;
    localparam int NB = 10;
`endif
    localparam int FC = NB * CPB;

    logic       clk;
    logic       rst;
    logic       tvalid;
    logic [7:0] tdata;
    logic       tready;
    logic       txd;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB),
        .PARITY_ODD  (0)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_s_axis_tvalid(tvalid),
        .i_s_axis_tdata (tdata),
        .o_s_axis_tready(tready),
        .o_txd          (txd),
        .o_txd_busy     (busy)
    );

`ifdef UART_TX_PARITY_EN
    logic tready_o;
    logic txd_o;
    logic busy_o;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB),
        .PARITY_ODD  (1)
    ) dut_odd (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_s_axis_tvalid(tvalid),
        .i_s_axis_tdata (tdata),
        .o_s_axis_tready(tready_o),
        .o_txd          (txd_o),
        .o_txd_busy     (busy_o)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // frame: bit i is the i-th bit on the line for an 8N1 frame
    // (start at [0], data LSB first at [8:1], stop at [9]); par = even parity.
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] full_frame(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return {2'b11, v.par, v.frame[8:0]};
`else
        return {2'b00, v.frame};
`endif
    endfunction

    task automatic send_from_idle(input logic [7:0] d);
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = d;
        chk("tready_idle", tready, 1'b1);
        @(posedge clk);
    endtask

    // Checks one whole frame cycle by cycle. At cycle next_at the source
    // offers next_data (if next_valid) and holds it until accepted.
    task automatic frame_check(input vec_t v, input int next_at,
                               input logic next_valid, input logic [7:0] next_data);
        logic [11:0] f;
        f = full_frame(v);
        for (int c = 0; c < FC; c++) begin
            @(negedge clk);
            if (c == 0) begin
                tvalid = 1'b0;
                tdata  = ~tdata;
            end
            if (c == next_at) begin
                tvalid = next_valid;
                tdata  = next_data;
            end
            chk("txd_bit", txd, f[c / CPB]);
            chk("busy_frame", busy, 1'b1);
            chk("tready_frame", tready, c == FC - 1);
`ifdef UART_TX_PARITY_EN
            chk("txd_odd_bit", txd_o, f[c / CPB] ^ (c / CPB == 9));
`endif
        end
    endtask

    task automatic idle_check(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_txd", txd, 1'b1);
            chk("idle_busy", busy, 1'b0);
            chk("idle_tready", tready, 1'b1);
        end
    endtask

    initial begin
        logic [11:0] f55;

        vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
        vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
        vecs[3] = '{8'h3C, 10'b1_00111100_0, 1'b0};
        vecs[4] = '{8'h55, 10'b1_01010101_0, 1'b0};
        vecs[5] = '{8'h01, 10'b1_00000001_0, 1'b1};
        vecs[6] = '{8'h80, 10'b1_10000000_0, 1'b1};
        vecs[7] = '{8'h07, 10'b1_00000111_0, 1'b1};

        rst    = 1'b1;
        tvalid = 1'b0;
        tdata  = 8'h00;

        // Reset held three cycles
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_txd", txd, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_tready", tready, 1'b0);
        end
        rst = 1'b0;
        idle_check(4);

        // Single frames from idle
        for (int i = 0; i < 8; i++) begin
            send_from_idle(vecs[i].data);
            frame_check(vecs[i], 0, 1'b0, 8'h00);
            idle_check(3);
        end

        // Back-to-back 0x00 then 0xFF with tvalid held high
        send_from_idle(8'h00);
        frame_check(vecs[1], 0, 1'b1, 8'hFF);
        frame_check(vecs[2], 0, 1'b0, 8'h00);
        idle_check(2);

        // Backpressure: 0x3C offered mid-frame, sent next with no gap
        send_from_idle(8'hA5);
        frame_check(vecs[0], 50, 1'b1, 8'h3C);
        frame_check(vecs[3], 0, 1'b0, 8'h00);
        idle_check(2);

        // Reset during data bit 3 of 0x55
        f55 = full_frame(vecs[4]);
        send_from_idle(8'h55);
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (c == 0) tvalid = 1'b0;
            chk("pre_rst_txd", txd, f55[c / CPB]);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_tready", tready, 1'b0);
        rst = 1'b0;
        idle_check(FC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
